// File: rtl/adas_pkg.sv
// Shared types and constants for the vehicle actuator interface.
// The state encoding is visible on state_o, so its values are fixed.
package adas_pkg;

   localparam int DUTY_W_DEF = 8;
   localparam int SPEED_W    = 8;

   localparam logic [DUTY_W_DEF-1:0] DUTY_ONES = '1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      DEAD  = 2'd2,
      BRAKE = 2'd3
   } state_t;

endpackage

// File: rtl/adas_speed_meter.sv
// Wheel speed meter.
// - Synchronizes the asynchronous encoder pulse and counts its rising edges.
// - Publishes the saturated count once every WINDOW_TICKS timer ticks.
// - An edge that lands in the window-end cycle opens the next window's count.
module adas_speed_meter
   import adas_pkg::*;
#(
   parameter int WINDOW_TICKS = 100
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               timer_tick,
   input  logic               wheel_pulse_i,
   output logic [SPEED_W-1:0] speed_measured_o
);

   localparam int TICK_W = $clog2(WINDOW_TICKS + 1);

   logic [1:0]         sync_reg;
   logic               prev_reg;
   logic [SPEED_W-1:0] edge_cnt_reg;
   logic [TICK_W-1:0]  tick_cnt_reg;
   logic [SPEED_W-1:0] speed_reg;
   logic               rise;
   logic               window_end;

   assign rise       = sync_reg[1] & ~prev_reg;
   assign window_end = timer_tick && (tick_cnt_reg == TICK_W'(WINDOW_TICKS - 1));

   // Two-flop synchronizer plus a delayed copy for rising-edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_reg <= '0;
         prev_reg <= 1'b0;
      end else begin
         sync_reg <= {sync_reg[0], wheel_pulse_i};
         prev_reg <= sync_reg[1];
      end
   end

   // Window timing, saturating edge count and result publication
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         edge_cnt_reg <= '0;
         tick_cnt_reg <= '0;
         speed_reg    <= '0;
      end else if (window_end) begin
         speed_reg    <= edge_cnt_reg;
         tick_cnt_reg <= '0;
         edge_cnt_reg <= rise ? SPEED_W'(1) : '0;
      end else begin
         if (timer_tick) begin
            tick_cnt_reg <= tick_cnt_reg + 1'b1;
         end
         if (rise && (edge_cnt_reg != '1)) begin
            edge_cnt_reg <= edge_cnt_reg + 1'b1;
         end
      end
   end

   assign speed_measured_o = speed_reg;

endmodule

// File: rtl/vehicle_actuator_if.sv
// Car-side actuator interface: arbitrates ADAS or pedal commands with brake
// priority, ramps and dead-times the duties, drives throttle/brake PWM and
// reports wheel speed.
// Optional build macro ADAS_SPEED_GOV_EN: forces the throttle target to zero
// while the measured speed is at or above SPEED_MAX.
module vehicle_actuator_if
   import adas_pkg::*;
#(
   parameter int DUTY_W       = DUTY_W_DEF,
   parameter int RAMP_STEP    = 4,
   parameter int DEAD_CYC     = 16,
   parameter int WINDOW_TICKS = 100,
   parameter int SPEED_MAX    = 120
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               timer_tick,
   input  logic               mode_i,
   input  logic               gas_i,
   input  logic               brake_i,
   input  logic [DUTY_W-1:0]  pedal_gas_i,
   input  logic [DUTY_W-1:0]  pedal_brake_i,
   input  logic               wheel_pulse_i,
   output logic               throttle_pwm_o,
   output logic               brake_pwm_o,
   output logic [SPEED_W-1:0] speed_measured_o,
   output logic [1:0]         state_o
);

`ifdef ADAS_SPEED_GOV_EN
   localparam bit GOV_EN = 1'b1;
`else
   localparam bit GOV_EN = 1'b0;
`endif

   localparam int                DEAD_W = $clog2(DEAD_CYC + 1);
   localparam logic [DUTY_W-1:0] ONES   = '1;
   localparam logic [DUTY_W-1:0] STEP_D = DUTY_W'(RAMP_STEP);

   state_t              state_reg;
   logic [DUTY_W-1:0]   thr_duty_reg;
   logic [DUTY_W-1:0]   brk_duty_reg;
   logic [DEAD_W-1:0]   dead_cnt_reg;
   logic [DUTY_W-1:0]   pwm_cnt_reg;
   logic [DUTY_W-1:0]   thr_tgt;
   logic [DUTY_W-1:0]   brk_tgt;
   logic [DUTY_W-1:0]   thr_ramp;
   logic [DUTY_W-1:0]   brk_ramp;
   logic [DUTY_W:0]     thr_sum;
   logic                gov_trip;
   logic                brake_req;
   logic                gas_req;
   logic [DUTY_W-1:0]   duty_ch [2];
   logic [1:0]          pwm_vec;

   adas_speed_meter #(
      .WINDOW_TICKS (WINDOW_TICKS)
   ) u_speed (
      .clk              (clk),
      .rst_n            (rst_n),
      .timer_tick       (timer_tick),
      .wheel_pulse_i    (wheel_pulse_i),
      .speed_measured_o (speed_measured_o)
   );

   assign gov_trip = GOV_EN && (int'(speed_measured_o) >= SPEED_MAX);

   // Command source selection and brake-wins arbitration
   always_comb begin
      thr_tgt = mode_i ? (gas_i ? ONES : '0) : pedal_gas_i;
      brk_tgt = mode_i ? (brake_i ? ONES : '0) : pedal_brake_i;
      if ((brk_tgt != '0) || gov_trip) begin
         thr_tgt = '0;
      end
   end

   assign brake_req = (brk_tgt != '0);
   assign gas_req   = (thr_tgt != '0);

   // Ramp candidates; the throttle sum carries an extra bit to catch overflow
   assign thr_sum  = {1'b0, thr_duty_reg} + {1'b0, STEP_D};
   assign thr_ramp = (thr_sum > {1'b0, thr_tgt}) ? thr_tgt : thr_sum[DUTY_W-1:0];
   assign brk_ramp = ((brk_duty_reg - brk_tgt) > STEP_D) ? (brk_duty_reg - STEP_D) : brk_tgt;

   // Actuation FSM: duties only ever nonzero in their own state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         thr_duty_reg <= '0;
         brk_duty_reg <= '0;
         dead_cnt_reg <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               thr_duty_reg <= '0;
               brk_duty_reg <= '0;
               if (brake_req) begin
                  state_reg    <= BRAKE;
                  brk_duty_reg <= brk_tgt;
               end else if (gas_req) begin
                  state_reg <= DRIVE;
               end
            end
            DRIVE: begin
               if (brake_req) begin
                  thr_duty_reg <= '0;
                  dead_cnt_reg <= '0;
                  state_reg    <= DEAD;
               end else if ((thr_duty_reg == '0) && !gas_req) begin
                  state_reg <= IDLE;
               end else if (thr_tgt < thr_duty_reg) begin
                  thr_duty_reg <= thr_tgt;
               end else if (timer_tick) begin
                  thr_duty_reg <= thr_ramp;
               end
            end
            DEAD: begin
               thr_duty_reg <= '0;
               brk_duty_reg <= '0;
               if (dead_cnt_reg == DEAD_W'(DEAD_CYC - 1)) begin
                  dead_cnt_reg <= '0;
                  if (brake_req) begin
                     state_reg    <= BRAKE;
                     brk_duty_reg <= brk_tgt;
                  end else begin
                     state_reg <= IDLE;
                  end
               end else begin
                  dead_cnt_reg <= dead_cnt_reg + 1'b1;
               end
            end
            BRAKE: begin
               if ((brk_duty_reg == '0) && !brake_req) begin
                  state_reg <= IDLE;
               end else if (brk_tgt >= brk_duty_reg) begin
                  brk_duty_reg <= brk_tgt;
               end else if (timer_tick) begin
                  brk_duty_reg <= brk_ramp;
               end
            end
            default: begin
               state_reg    <= IDLE;
               thr_duty_reg <= '0;
               brk_duty_reg <= '0;
            end
         endcase
      end
   end

   // Free-running PWM period counter shared by both channels
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_cnt_reg <= '0;
      end else begin
         pwm_cnt_reg <= pwm_cnt_reg + 1'b1;
      end
   end

   assign duty_ch[0] = thr_duty_reg;
   assign duty_ch[1] = brk_duty_reg;

   for (genvar gi = 0; gi < 2; gi++) begin : g_pwm
      logic pwm_reg;
      // Registered compare: high while the period counter is below the duty
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            pwm_reg <= 1'b0;
         end else begin
            pwm_reg <= (pwm_cnt_reg < duty_ch[gi]);
         end
      end
      assign pwm_vec[gi] = pwm_reg;
   end

   assign throttle_pwm_o = pwm_vec[0];
   assign brake_pwm_o    = pwm_vec[1];
   assign state_o        = state_reg;

endmodule

// File: tb/tb_vehicle_actuator_if.sv
// Directed self-checking bench for vehicle_actuator_if.
// Duty values are observed as the number of PWM-high cycles in one
// 256-cycle period, with timer_tick held low so the duty stays constant.
// Define ADAS_SPEED_GOV_EN for both bench and RTL to check the governor build.
module tb_vehicle_actuator_if;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       timer_tick = 1'b0;
   logic       mode_i = 1'b1;
   logic       gas_i = 1'b0;
   logic       brake_i = 1'b0;
   logic [7:0] pedal_gas_i = 8'd0;
   logic [7:0] pedal_brake_i = 8'd0;
   logic       wheel_pulse_i = 1'b0;
   logic       throttle_pwm_o;
   logic       brake_pwm_o;
   logic [7:0] speed_measured_o;
   logic [1:0] state_o;

   int checks = 0;
   int errors = 0;

   vehicle_actuator_if dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .timer_tick       (timer_tick),
      .mode_i           (mode_i),
      .gas_i            (gas_i),
      .brake_i          (brake_i),
      .pedal_gas_i      (pedal_gas_i),
      .pedal_brake_i    (pedal_brake_i),
      .wheel_pulse_i    (wheel_pulse_i),
      .throttle_pwm_o   (throttle_pwm_o),
      .brake_pwm_o      (brake_pwm_o),
      .speed_measured_o (speed_measured_o),
      .state_o          (state_o)
   );

   always #5 clk = ~clk;

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic tick_n(input int n);
      for (int i = 0; i < n; i++) begin
         timer_tick = 1'b1;
         step();
         timer_tick = 1'b0;
      end
   endtask

   task automatic measure(output int thr_hi, output int brk_hi, output int both);
      thr_hi = 0;
      brk_hi = 0;
      both   = 0;
      step();
      step();
      for (int i = 0; i < 256; i++) begin
         step();
         if (throttle_pwm_o === 1'b1) thr_hi++;
         if (brake_pwm_o === 1'b1) brk_hi++;
         if ((throttle_pwm_o === 1'b1) && (brake_pwm_o === 1'b1)) both++;
      end
   endtask

   task automatic pulses(input int n);
      for (int i = 0; i < n; i++) begin
         wheel_pulse_i = 1'b1;
         step();
         step();
         wheel_pulse_i = 1'b0;
         step();
         step();
      end
      for (int i = 0; i < 4; i++) step();
   endtask

   task automatic do_reset();
      mode_i = 1'b1;
      gas_i = 1'b0;
      brake_i = 1'b0;
      pedal_gas_i = 8'd0;
      pedal_brake_i = 8'd0;
      wheel_pulse_i = 1'b0;
      timer_tick = 1'b0;
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state_o); end
      checks++; if (throttle_pwm_o !== 1'b0) begin errors++; $display("FAIL reset_thr_pwm got %b exp 0", throttle_pwm_o); end
      checks++; if (brake_pwm_o !== 1'b0) begin errors++; $display("FAIL reset_brk_pwm got %b exp 0", brake_pwm_o); end
      checks++; if (speed_measured_o !== 8'd0) begin errors++; $display("FAIL reset_speed got %0d exp 0", speed_measured_o); end
      step();
      checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL idle_hold_state got %0d exp 0", state_o); end
      $display("test_reset: done");
   endtask

   task automatic test_ramp_40();
      int t, b, x;
      mode_i = 1'b1;
      gas_i = 1'b1;
      step();
      checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL ramp_enter_drive got %0d exp 1", state_o); end
      tick_n(10);
      measure(t, b, x);
      checks++; if (t != 40) begin errors++; $display("FAIL ramp10_thr_duty got %0d exp 40", t); end
      checks++; if (b != 0) begin errors++; $display("FAIL ramp10_brk_duty got %0d exp 0", b); end
      checks++; if (x != 0) begin errors++; $display("FAIL ramp10_overlap got %0d exp 0", x); end
      checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL ramp10_state got %0d exp 1", state_o); end
      $display("test_ramp_40: done");
   endtask

   task automatic test_reset_mid_drive();
      rst_n = 1'b0;
      #1;
      checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL async_rst_state got %0d exp 0", state_o); end
      checks++; if (throttle_pwm_o !== 1'b0) begin errors++; $display("FAIL async_rst_thr_pwm got %b exp 0", throttle_pwm_o); end
      checks++; if (brake_pwm_o !== 1'b0) begin errors++; $display("FAIL async_rst_brk_pwm got %b exp 0", brake_pwm_o); end
      checks++; if (speed_measured_o !== 8'd0) begin errors++; $display("FAIL async_rst_speed got %0d exp 0", speed_measured_o); end
      gas_i = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      step();
      $display("test_reset_mid_drive: done");
   endtask

   task automatic test_ramp_full();
      int t, b, x;
      gas_i = 1'b1;
      step();
      checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL full_enter_drive got %0d exp 1", state_o); end
      tick_n(64);
      measure(t, b, x);
      checks++; if (t != 255) begin errors++; $display("FAIL ramp64_thr_duty got %0d exp 255", t); end
      checks++; if (b != 0) begin errors++; $display("FAIL ramp64_brk_duty got %0d exp 0", b); end
      $display("test_ramp_full: done");
   endtask

   task automatic test_brake_dead();
      int t, b, x;
      int overlap;
      overlap = 0;
      brake_i = 1'b1;
      step();
      checks++; if (state_o !== 2'd2) begin errors++; $display("FAIL dead_enter got %0d exp 2", state_o); end
      step();
      checks++; if (throttle_pwm_o !== 1'b0) begin errors++; $display("FAIL dead_thr_pwm_off got %b exp 0", throttle_pwm_o); end
      for (int i = 0; i < 14; i++) begin
         step();
         if (throttle_pwm_o === 1'b1 && brake_pwm_o === 1'b1) overlap++;
      end
      checks++; if (state_o !== 2'd2) begin errors++; $display("FAIL dead_16th_cycle got %0d exp 2", state_o); end
      step();
      checks++; if (state_o !== 2'd3) begin errors++; $display("FAIL dead_expiry got %0d exp 3", state_o); end
      checks++; if (overlap != 0) begin errors++; $display("FAIL dead_overlap got %0d exp 0", overlap); end
      measure(t, b, x);
      checks++; if (b != 255) begin errors++; $display("FAIL brake_full_duty got %0d exp 255", b); end
      checks++; if (t != 0) begin errors++; $display("FAIL brake_thr_duty got %0d exp 0", t); end
      checks++; if (x != 0) begin errors++; $display("FAIL brake_overlap got %0d exp 0", x); end
      $display("test_brake_dead: done");
   endtask

   task automatic test_manual_brake();
      int t, b, x;
      do_reset();
      mode_i = 1'b0;
      pedal_brake_i = 8'd200;
      pedal_gas_i = 8'd100;
      step();
      checks++; if (state_o !== 2'd3) begin errors++; $display("FAIL man_enter_brake got %0d exp 3", state_o); end
      measure(t, b, x);
      checks++; if (b != 200) begin errors++; $display("FAIL man_brk_200 got %0d exp 200", b); end
      checks++; if (t != 0) begin errors++; $display("FAIL man_gas_blocked got %0d exp 0", t); end
      pedal_brake_i = 8'd0;
      tick_n(25);
      measure(t, b, x);
      checks++; if (b != 100) begin errors++; $display("FAIL man_brk_25ticks got %0d exp 100", b); end
      checks++; if (t != 0) begin errors++; $display("FAIL man_gas_ignored got %0d exp 0", t); end
      checks++; if (state_o !== 2'd3) begin errors++; $display("FAIL man_still_brake got %0d exp 3", state_o); end
      tick_n(25);
      checks++; if (state_o !== 2'd3) begin errors++; $display("FAIL man_50ticks_state got %0d exp 3", state_o); end
      step();
      checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL man_to_idle got %0d exp 0", state_o); end
      step();
      checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL man_to_drive got %0d exp 1", state_o); end
      $display("test_manual_brake: done");
   endtask

   task automatic test_speed();
      do_reset();
      pulses(37);
      tick_n(99);
      checks++; if (speed_measured_o !== 8'd0) begin errors++; $display("FAIL speed_before_end got %0d exp 0", speed_measured_o); end
      tick_n(1);
      checks++; if (speed_measured_o !== 8'd37) begin errors++; $display("FAIL speed_37 got %0d exp 37", speed_measured_o); end
      pulses(300);
      tick_n(100);
      checks++; if (speed_measured_o !== 8'd255) begin errors++; $display("FAIL speed_sat got %0d exp 255", speed_measured_o); end
      tick_n(99);
      wheel_pulse_i = 1'b1;
      step();
      step();
      timer_tick = 1'b1;
      step();
      timer_tick = 1'b0;
      wheel_pulse_i = 1'b0;
      checks++; if (speed_measured_o !== 8'd0) begin errors++; $display("FAIL speed_edge_window got %0d exp 0", speed_measured_o); end
      for (int i = 0; i < 4; i++) step();
      tick_n(100);
      checks++; if (speed_measured_o !== 8'd1) begin errors++; $display("FAIL speed_edge_next got %0d exp 1", speed_measured_o); end
      $display("test_speed: done");
   endtask

   task automatic test_governor();
      int t, b, x;
      do_reset();
      pulses(125);
      tick_n(100);
      checks++; if (speed_measured_o !== 8'd125) begin errors++; $display("FAIL gov_speed got %0d exp 125", speed_measured_o); end
      mode_i = 1'b1;
      gas_i = 1'b1;
      step();
      tick_n(5);
      measure(t, b, x);
`ifdef ADAS_SPEED_GOV_EN
      checks++; if (t != 0) begin errors++; $display("FAIL gov_thr_duty got %0d exp 0", t); end
      checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL gov_state got %0d exp 0", state_o); end
`else
      checks++; if (t != 20) begin errors++; $display("FAIL nogov_thr_duty got %0d exp 20", t); end
      checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL nogov_state got %0d exp 1", state_o); end
`endif
      $display("test_governor: done");
   endtask

   initial begin
      test_reset();
      test_ramp_40();
      test_reset_mid_drive();
      test_ramp_full();
      test_brake_dead();
      test_manual_brake();
      test_speed();
      test_governor();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
